// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned ENTRY_PC_W = 32;

    localparam logic [6:0]         OPC_SYSTEM = 7'h73;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Prefetch queue payload; the PC field holds up to ENTRY_PC_W address bits.
    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is presented combinationally from storage.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Decoupled IF stage: PC generation, pipelined imem requests with credit limit,
// prefetch queue feeding IF/ID, redirect squash and ECALL halt.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  B_J_pc_EX,
    input  logic               B_J_EX,
    input  logic               lw_stall,
    input  logic               br_stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid_IF_ID,
    output logic [ADDR_W-1:0]  pc_IF_ID,
    output logic [INSTR_W-1:0] instr_IF_ID,
    output logic               halted
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0] resp_pc, resp_pc_next;
    logic [CNT_W-1:0]  outstanding, outstanding_next;
    logic [CNT_W-1:0]  drop_cnt, drop_cnt_next;
    logic [CNT_W-1:0]  count;
    logic              req;
    logic              push;
    logic              pop;
    logic              ecall_push;
    logic              head_valid;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (B_J_EX),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (count)
    );

    assign head_valid = (count != '0);
    assign pop        = head_valid & ~(lw_stall | br_stall);

    // Request/response qualification; queued + in-flight never exceeds DEPTH.
    always_comb begin
        req = 1'b0;
        if (!rst && state == RUN && !B_J_EX &&
            (SUM_W'(count) + SUM_W'(outstanding) < SUM_W'(DEPTH))) begin
            req = 1'b1;
        end
        push             = imem_rvalid & (drop_cnt == '0) & ~B_J_EX;
        ecall_push       = push & (imem_rdata[6:0] == OPC_SYSTEM);
        push_entry.pc    = ENTRY_PC_W'(resp_pc);
        push_entry.instr = imem_rdata;
    end

    // Next-state: redirect dominates; an ECALL push squashes everything still in flight.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;
        drop_cnt_next    = drop_cnt;
        outstanding_next = outstanding;

        case ({req, imem_rvalid})
            2'b10:   outstanding_next = outstanding + CNT_W'(1);
            2'b01:   outstanding_next = outstanding - CNT_W'(1);
            default: ;
        endcase

        if (B_J_EX) begin
            state_next    = RUN;
            fetch_pc_next = B_J_pc_EX;
            resp_pc_next  = B_J_pc_EX;
            drop_cnt_next = outstanding_next;
        end else begin
            if (req)  fetch_pc_next = fetch_pc + PC_STEP;
            if (push) resp_pc_next  = resp_pc + PC_STEP;
            if (ecall_push) begin
                state_next    = HALT;
                drop_cnt_next = outstanding_next;
            end else if (imem_rvalid && drop_cnt != '0) begin
                drop_cnt_next = drop_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = fetch_pc;
    assign valid_IF_ID = head_valid;
    assign pc_IF_ID    = ADDR_W'(head_entry.pc);
    assign instr_IF_ID = head_valid ? head_entry.instr : NOP_INSTR;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: in-order variable-latency imem model plus a
// second instance with a near-top RESET_PC for address wrap.
module tb_fetch_prefetch;

    logic        clk;
    logic        rst;
    logic [31:0] B_J_pc_EX;
    logic        B_J_EX;
    logic        lw_stall;
    logic        br_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_IF_ID;
    logic [31:0] pc_IF_ID;
    logic [31:0] instr_IF_ID;
    logic        halted;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_halted;

    int          checks;
    int          errors;
    int          lat;
    int          cyc;
    int          tcyc;
    logic [31:0] ecall_addr;

    logic [31:0] req_log[$];
    logic [31:0] popped[$];
    logic [31:0] w_req_log[$];
    logic [31:0] w_popped[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic        w_pend_v;
    logic [31:0] w_pend_a;

    fetch_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .B_J_pc_EX(B_J_pc_EX), .B_J_EX(B_J_EX),
        .lw_stall(lw_stall), .br_stall(br_stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_IF_ID(valid_IF_ID), .pc_IF_ID(pc_IF_ID),
        .instr_IF_ID(instr_IF_ID), .halted(halted)
    );

    fetch_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .B_J_pc_EX(B_J_pc_EX), .B_J_EX(B_J_EX),
        .lw_stall(lw_stall), .br_stall(br_stall),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .valid_IF_ID(w_valid), .pc_IF_ID(w_pc),
        .instr_IF_ID(w_instr), .halted(w_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == ecall_addr) return 32'h0000_0073;
        return {addr[24:0], 7'h13} ^ {addr[31:25], 25'h0};
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requests are captured mid-cycle; responses are presented after the edge, in order.
    always @(negedge clk) begin
        if (!rst && imem_req) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(imem_addr);
        end
        w_pend_v = !rst && w_req;
        w_pend_a = w_addr;
        if (!rst && w_req) w_req_log.push_back(w_addr);
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
            w_rvalid    = 1'b0;
        end else begin
            if (imem_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr[0]);
            end else begin
                imem_rvalid = 1'b0;
            end
            w_rvalid = w_pend_v;
            w_rdata  = mem_word(w_pend_a);
        end
    end

    // Every consumed IF/ID entry is logged and its instruction checked.
    always @(negedge clk) begin
        if (!rst && !lw_stall && !br_stall && !B_J_EX) begin
            if (valid_IF_ID) begin
                popped.push_back(pc_IF_ID);
                check("pop_instr", instr_IF_ID, mem_word(pc_IF_ID));
            end
            if (w_valid) begin
                w_popped.push_back(w_pc);
                check("w_pop_instr", w_instr, mem_word(w_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        tcyc++;
    endtask

    task automatic drive_at(input int n);
        while (tcyc < n) step();
    endtask

    task automatic goto(input int n);
        while (tcyc < n) step();
        @(negedge clk);
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #2;
        req_log.delete();
        popped.delete();
        w_req_log.delete();
        w_popped.delete();
        rst  = 1'b0;
        tcyc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        B_J_EX   = 1'b0;
        lw_stall = 1'b0;
        br_stall = 1'b0;
        release_rst();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        tcyc       = 0;
        lat        = 1;
        ecall_addr = 32'hDEAD_BEE0;
        rst        = 1'b1;
        B_J_EX     = 1'b0;
        B_J_pc_EX  = 32'h0;
        lw_stall   = 1'b0;
        br_stall   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        w_pend_v    = 1'b0;
        w_pend_a    = 32'h0;

        @(negedge clk);
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(valid_IF_ID), 32'd0);
        check("rst_instr", instr_IF_ID, 32'h13);
        check("rst_halt",  32'(halted), 32'd0);

        // Straight-line, latency 1
        lat = 1;
        do_reset();
        goto(0);
        check("t1_req0",  32'(imem_req), 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_val0",  32'(valid_IF_ID), 32'd0);
        goto(1);
        check("t1_addr1", imem_addr, 32'h4);
        check("t1_val1",  32'(valid_IF_ID), 32'd0);
        goto(2);
        check("t1_val2",  32'(valid_IF_ID), 32'd1);
        check("t1_pc2",   pc_IF_ID, 32'h0);
        goto(3);
        check("t1_pc3",   pc_IF_ID, 32'h4);
        goto(12);
        for (int i = 0; i < 8; i++) begin
            check("t1_reqseq", qget(req_log, i), 32'(4 * i));
            check("t1_popseq", qget(popped, i), 32'(4 * i));
        end

        // Load-use stall fills the queue, latency 2
        lat = 2;
        do_reset();
        lw_stall = 1'b1;
        goto(3);
        check("t2_val3", 32'(valid_IF_ID), 32'd1);
        check("t2_pc3",  pc_IF_ID, 32'h0);
        goto(5);
        check("t2_req5",  32'(imem_req), 32'd0);
        check("t2_pc5",   pc_IF_ID, 32'h0);
        check("t2_nreq",  32'(req_log.size()), 32'd4);
        drive_at(6);
        lw_stall = 1'b0;
        goto(25);
        for (int i = 0; i < 8; i++) begin
            check("t2_popseq", qget(popped, i), 32'(4 * i));
        end

        // Redirect with 3 outstanding, latency 3
        lat = 3;
        do_reset();
        drive_at(3);
        B_J_EX    = 1'b1;
        B_J_pc_EX = 32'h100;
        goto(3);
        check("t3_req_redir", 32'(imem_req), 32'd0);
        drive_at(4);
        B_J_EX = 1'b0;
        goto(4);
        check("t3_req4",  32'(imem_req), 32'd1);
        check("t3_addr4", imem_addr, 32'h100);
        goto(7);
        check("t3_val7",  32'(valid_IF_ID), 32'd0);
        goto(8);
        check("t3_val8",   32'(valid_IF_ID), 32'd1);
        check("t3_pc8",    pc_IF_ID, 32'h100);
        check("t3_instr8", instr_IF_ID, mem_word(32'h100));
        goto(12);
        for (int i = 0; i < 3; i++) begin
            check("t3_popseq", qget(popped, i), 32'h100 + 32'(4 * i));
        end

        // Redirect coincident with rvalid and lw_stall, latency 1
        lat = 1;
        do_reset();
        lw_stall = 1'b1;
        drive_at(3);
        B_J_EX    = 1'b1;
        B_J_pc_EX = 32'h200;
        goto(3);
        check("t4_req3", 32'(imem_req), 32'd0);
        check("t4_val3", 32'(valid_IF_ID), 32'd1);
        check("t4_pc3",  pc_IF_ID, 32'h0);
        drive_at(4);
        B_J_EX   = 1'b0;
        lw_stall = 1'b0;
        goto(4);
        check("t4_val4",  32'(valid_IF_ID), 32'd0);
        check("t4_req4",  32'(imem_req), 32'd1);
        check("t4_addr4", imem_addr, 32'h200);
        goto(6);
        check("t4_val6", 32'(valid_IF_ID), 32'd1);
        check("t4_pc6",  pc_IF_ID, 32'h200);
        goto(8);
        check("t4_pop0", qget(popped, 0), 32'h200);

        // ECALL at 0x8 halts; redirect resumes
        lat = 1;
        ecall_addr = 32'h8;
        do_reset();
        goto(4);
        check("t5_halt4",  32'(halted), 32'd1);
        check("t5_req4",   32'(imem_req), 32'd0);
        check("t5_pc4",    pc_IF_ID, 32'h8);
        check("t5_instr4", instr_IF_ID, 32'h73);
        goto(8);
        check("t5_val8",  32'(valid_IF_ID), 32'd0);
        check("t5_halt8", 32'(halted), 32'd1);
        check("t5_req8",  32'(imem_req), 32'd0);
        check("t5_npop",  32'(popped.size()), 32'd3);
        check("t5_pop2",  qget(popped, 2), 32'h8);
        drive_at(9);
        B_J_EX    = 1'b1;
        B_J_pc_EX = 32'h40;
        goto(9);
        check("t5_req9", 32'(imem_req), 32'd0);
        drive_at(10);
        B_J_EX = 1'b0;
        goto(10);
        check("t5_halt10", 32'(halted), 32'd0);
        check("t5_req10",  32'(imem_req), 32'd1);
        check("t5_addr10", imem_addr, 32'h40);
        goto(12);
        check("t5_val12", 32'(valid_IF_ID), 32'd1);
        check("t5_pc12",  pc_IF_ID, 32'h40);
        ecall_addr = 32'hDEAD_BEE0;

        // PC wrap from RESET_PC near top, then async reset mid-burst
        lat = 1;
        do_reset();
        goto(5);
        check("t6_wreq0", qget(w_req_log, 0), 32'hFFFF_FFF8);
        check("t6_wreq1", qget(w_req_log, 1), 32'hFFFF_FFFC);
        check("t6_wreq2", qget(w_req_log, 2), 32'h0);
        check("t6_wreq3", qget(w_req_log, 3), 32'h4);
        check("t6_wpop0", qget(w_popped, 0), 32'hFFFF_FFF8);
        check("t6_wpop1", qget(w_popped, 1), 32'hFFFF_FFFC);
        check("t6_wpop2", qget(w_popped, 2), 32'h0);
        check("t6_busy",  32'(imem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_req",    32'(imem_req), 32'd0);
        check("t6_rst_valid",  32'(valid_IF_ID), 32'd0);
        check("t6_rst_instr",  instr_IF_ID, 32'h13);
        check("t6_rst_halt",   32'(halted), 32'd0);
        check("t6_rst_addr",   imem_addr, 32'h0);
        check("t6_rst_waddr",  w_addr, 32'hFFFF_FFF8);
        check("t6_rst_wvalid", 32'(w_valid), 32'd0);
        check("t6_rst_whalt",  32'(w_halted), 32'd0);
        release_rst();
        goto(0);
        check("t6_post_req",   32'(imem_req), 32'd1);
        check("t6_post_addr",  imem_addr, 32'h0);
        check("t6_post_waddr", w_addr, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
